pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control block that sits directly upstream and downstream of the forwarding/hazard unit.
- Tracks the opcode and destination register of the instructions in EX/MEM and MEM/WB, and supplies the forwarding unit's history inputs (previous/pre-previous opcode, EX_MEM_RD, MEM_WB_RD, load flag).
- Consumes that unit's STALL output together with the branch-redirect signal from EX, and produces the PC, IF/ID and ID/EX pipeline-register controls.
- Keeps saturating stall/flush event counters and a sticky protocol-error flag.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ID_OPCODE  in  7  opcode of the instruction currently in ID
- ID_RD  in  5  rd field of the instruction in ID
- ID_WRITES_RD  in  1  instruction in ID writes rd (0 for STORE/BRANCH)
- ID_VALID  in  1  ID holds a real instruction
- STALL  in  1  load-use stall request from the forwarding unit
- BR_TAKEN  in  1  EX resolved a taken branch or jump this cycle
- CNT_CLR  in  1  synchronous clear of both counters
- OPCODE_PREV  out  7  opcode in the EX/MEM slot
- OPCODE_PREVPREV  out  7  opcode in the MEM/WB slot
- EX_MEM_RD  out  5  rd in the EX/MEM slot; 0 if that slot does not write
- MEM_WB_RD  out  5  rd in the MEM/WB slot; 0 if that slot does not write
- LOAD  out  1  EX/MEM slot holds a LOAD (opcode 7'b0000011)
- PC_WE  out  1  PC register write enable
- IFID_WE  out  1  IF/ID register write enable
- IFID_FLUSH  out  1  IF/ID register loads a NOP
- IDEX_BUBBLE  out  1  ID/EX register loads a bubble instead of the ID contents
- STALL_CNT  out  CNT_W  number of load-use stall cycles
- FLUSH_CNT  out  CNT_W  number of taken-branch flushes
- ERR_STALL2  out  1  sticky flag: STALL was asserted in consecutive cycles

## Operation
- History slots: EX/MEM slot {op, rd} and MEM/WB slot {op, rd}.
  - A bubble is op = 7'b0000000, rd = 0.
  - Every clock, the MEM/WB slot takes the EX/MEM slot.
  - The EX/MEM slot takes {ID_OPCODE, ID_WRITES_RD ? ID_RD : 0}, or a bubble when ISSUE = 0.
- ISSUE = ID_VALID & ~STALL_EFF & ~BR_TAKEN & (state != FLUSH).
- STALL_EFF = STALL & ~BR_TAKEN & (state != FLUSH). A branch squashes the stalled instruction, so BR_TAKEN has priority over STALL.
- FSM states: RUN, LDSTALL, FLUSH. Reset state is RUN.
  - RUN: BR_TAKEN -> FLUSH; else STALL -> LDSTALL; else stay in RUN.
  - LDSTALL: lasts one cycle. BR_TAKEN -> FLUSH; STALL -> stay in LDSTALL and set ERR_STALL2; else -> RUN.
  - FLUSH: the instruction in ID is a flushed NOP. STALL is ignored. BR_TAKEN -> FLUSH; else -> RUN.
- Controls are combinational from the inputs and state:
  - PC_WE = ~STALL_EFF.
  - IFID_WE = ~STALL_EFF.
  - IFID_FLUSH = BR_TAKEN.
  - IDEX_BUBBLE = ~ISSUE.
- LOAD = (OPCODE_PREV == 7'b0000011).
- Counters:
  - STALL_CNT increments on each cycle with STALL_EFF.
  - FLUSH_CNT increments on each cycle with BR_TAKEN.
  - Both saturate at all-ones; there is no wrap.
  - CNT_CLR has priority over an increment in the same cycle.
- ERR_STALL2 is cleared only by RST.

## Timing
- Reset values, all immediate on RST assertion:
  - history slots are bubbles, so OPCODE_PREV = OPCODE_PREVPREV = 0, EX_MEM_RD = MEM_WB_RD = 0, LOAD = 0;
  - state = RUN;
  - counters = 0; ERR_STALL2 = 0;
  - while RST is high, PC_WE = IFID_WE = IFID_FLUSH = 0 and IDEX_BUBBLE = 1.
- History latency:
  - an instruction in ID at cycle n appears on OPCODE_PREV/EX_MEM_RD at cycle n+1 and on OPCODE_PREVPREV/MEM_WB_RD at n+2;
  - a stall or flush inserts exactly one bubble per cycle.
- Load-use stall: STALL at cycle n gives PC_WE = IFID_WE = 0 and IDEX_BUBBLE = 1 in cycle n. At n+1, LOAD = 0 and EX_MEM_RD = 0, so the forwarding unit drops STALL and the instruction issues.
- Branch: BR_TAKEN at cycle n:
  - in cycle n: IFID_FLUSH = 1, IDEX_BUBBLE = 1, PC_WE = 1;
  - at n+1: state FLUSH and IDEX_BUBBLE = 1.
  - This gives two bubbles in total.
- Counter values are visible one cycle after the event.
- RST asserted mid-stall or mid-flush: abandon the state immediately and return to RUN with reset values.

## Test plan
- Reset: assert RST mid-operation -> all history outputs 0, counters 0, IDEX_BUBBLE = 1, PC_WE = 0; after release with ID_VALID = 1 -> PC_WE = 1.
- Pipeline: issue ADDI rd = 5, then ADD rd = 6 -> cycle+1 EX_MEM_RD = 5; cycle+2 MEM_WB_RD = 5 and EX_MEM_RD = 6.
- Store handling: ID holds STORE with ID_RD = 9 and ID_WRITES_RD = 0 -> next cycle OPCODE_PREV = 7'b0100011, EX_MEM_RD = 0.
- Load-use: LW rd = 3, then STALL = 1 for one cycle -> LOAD = 1 during the stall cycle, PC_WE = IFID_WE = 0, IDEX_BUBBLE = 1; next cycle EX_MEM_RD = 0 and STALL_CNT = 1.
- Branch priority: STALL = 1 and BR_TAKEN = 1 together -> PC_WE = 1, IFID_FLUSH = 1, STALL_CNT unchanged, FLUSH_CNT = 1; next cycle IDEX_BUBBLE = 1 even if STALL = 1.
- Saturation and error: preload STALL_CNT to 16'hFFFF and stall -> stays 16'hFFFF; STALL held for 2 cycles -> ERR_STALL2 = 1 until RST.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline control block and the surrounding
// ID/EX stages and forwarding unit.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       ID_OPCODE;
    logic [4:0]       ID_RD;
    logic             ID_WRITES_RD;
    logic             ID_VALID;
    logic             STALL;
    logic             BR_TAKEN;
    logic             CNT_CLR;
    logic [6:0]       OPCODE_PREV;
    logic [6:0]       OPCODE_PREVPREV;
    logic [4:0]       EX_MEM_RD;
    logic [4:0]       MEM_WB_RD;
    logic             LOAD;
    logic             PC_WE;
    logic             IFID_WE;
    logic             IFID_FLUSH;
    logic             IDEX_BUBBLE;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;
    logic             ERR_STALL2;

    modport master (
        output ID_OPCODE, ID_RD, ID_WRITES_RD, ID_VALID, STALL, BR_TAKEN, CNT_CLR,
        input  OPCODE_PREV, OPCODE_PREVPREV, EX_MEM_RD, MEM_WB_RD, LOAD,
        input  PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STALL_CNT, FLUSH_CNT, ERR_STALL2
    );

    modport slave (
        input  ID_OPCODE, ID_RD, ID_WRITES_RD, ID_VALID, STALL, BR_TAKEN, CNT_CLR,
        output OPCODE_PREV, OPCODE_PREVPREV, EX_MEM_RD, MEM_WB_RD, LOAD,
        output PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STALL_CNT, FLUSH_CNT, ERR_STALL2
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: EX/MEM and MEM/WB history for the forwarding unit,
// PC/IF-ID/ID-EX controls from stall and branch redirect, event counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_e;

    state_e           state_q, state_d;
    logic [6:0]       ex_op_q, ex_op_d, wb_op_q;
    logic [4:0]       ex_rd_q, ex_rd_d, wb_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             err_q, err_d;
    logic             in_flush;
    logic             stall_eff;
    logic             issue;

    always_comb begin
        in_flush  = (state_q == FLUSH);
        // A taken branch squashes the stalled instruction, so it wins over STALL.
        stall_eff = bus.STALL & ~bus.BR_TAKEN & ~in_flush;
        issue     = bus.ID_VALID & ~stall_eff & ~bus.BR_TAKEN & ~in_flush & ~RST;

        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (bus.BR_TAKEN)   state_d = FLUSH;
                else if (bus.STALL) state_d = LDSTALL;
            end
            LDSTALL: begin
                if (bus.BR_TAKEN) begin
                    state_d = FLUSH;
                end else if (bus.STALL) begin
                    state_d = LDSTALL;
                    err_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = bus.BR_TAKEN ? FLUSH : RUN;
            default: state_d = RUN;
        endcase

        ex_op_d = issue ? bus.ID_OPCODE : '0;
        ex_rd_d = (issue & bus.ID_WRITES_RD) ? bus.ID_RD : '0;

        stall_cnt_d = stall_cnt_q;
        if (bus.CNT_CLR)
            stall_cnt_d = '0;
        else if (stall_eff && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (bus.CNT_CLR)
            flush_cnt_d = '0;
        else if (bus.BR_TAKEN && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);

        // Controls are forced to their safe values for as long as RST is held.
        bus.PC_WE       = ~stall_eff & ~RST;
        bus.IFID_WE     = ~stall_eff & ~RST;
        bus.IFID_FLUSH  = bus.BR_TAKEN & ~RST;
        bus.IDEX_BUBBLE = ~issue;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RUN;
            ex_op_q     <= '0;
            ex_rd_q     <= '0;
            wb_op_q     <= '0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            wb_op_q     <= ex_op_q;
            wb_rd_q     <= ex_rd_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.OPCODE_PREV     = ex_op_q;
    assign bus.OPCODE_PREVPREV = wb_op_q;
    assign bus.EX_MEM_RD       = ex_rd_q;
    assign bus.MEM_WB_RD       = wb_rd_q;
    assign bus.LOAD            = (ex_op_q == OP_LOAD);
    assign bus.STALL_CNT       = stall_cnt_q;
    assign bus.FLUSH_CNT       = flush_cnt_q;
    assign bus.ERR_STALL2      = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a cycle-level
// reference model; a narrow counter width makes saturation reachable.
module tb_pipe_hazard_ctrl;
    localparam int          CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_hazard_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
    } slot_t;

    // Reference model: the two in-flight slots, whether the previous cycle
    // redirected or stalled, counters as plain integers.
    slot_t       hist [2];
    bit          m_prev_br, m_prev_stall, m_err;
    int unsigned m_scnt, m_fcnt;

    int unsigned ncmp  = 0;
    int unsigned nfail = 0;
    logic [6:0]  ops [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist[0] = '0;
        hist[1] = '0;
        m_prev_br = 0; m_prev_stall = 0; m_err = 0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic check_and_step();
        logic flush, seff, iss;
        flush = m_prev_br;
        seff  = bus.STALL && !bus.BR_TAKEN && !flush;
        iss   = bus.ID_VALID && !seff && !bus.BR_TAKEN && !flush;
        check("op_prev",     bus.OPCODE_PREV,     hist[0].op);
        check("op_prevprev", bus.OPCODE_PREVPREV, hist[1].op);
        check("ex_mem_rd",   bus.EX_MEM_RD,       hist[0].rd);
        check("mem_wb_rd",   bus.MEM_WB_RD,       hist[1].rd);
        check("load",        bus.LOAD,            hist[0].op == OP_LOAD);
        check("pc_we",       bus.PC_WE,           !seff);
        check("ifid_we",     bus.IFID_WE,         !seff);
        check("ifid_flush",  bus.IFID_FLUSH,      bus.BR_TAKEN);
        check("idex_bubble", bus.IDEX_BUBBLE,     !iss);
        check("stall_cnt",   bus.STALL_CNT,       m_scnt);
        check("flush_cnt",   bus.FLUSH_CNT,       m_fcnt);
        check("err_stall2",  bus.ERR_STALL2,      m_err);

        if (m_prev_stall && seff) m_err = 1;
        hist[1] = hist[0];
        if (iss) hist[0] = '{op: bus.ID_OPCODE, rd: bus.ID_WRITES_RD ? bus.ID_RD : 5'd0};
        else     hist[0] = '0;
        if (bus.CNT_CLR) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (seff && m_scnt < CMAX)         m_scnt++;
            if (bus.BR_TAKEN && m_fcnt < CMAX) m_fcnt++;
        end
        m_prev_br    = bus.BR_TAKEN;
        m_prev_stall = seff;
    endtask

    task automatic cycle(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic wr, input logic st, input logic br, input logic clr);
        @(negedge CLK);
        bus.ID_VALID     = v;
        bus.ID_OPCODE    = op;
        bus.ID_RD        = rd;
        bus.ID_WRITES_RD = wr;
        bus.STALL        = st;
        bus.BR_TAKEN     = br;
        bus.CNT_CLR      = clr;
        #1;
        check_and_step();
    endtask

    // Asserts RST mid-cycle with hostile inputs, checks the immediate values,
    // then releases on a negedge and runs one idle checked cycle.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        bus.ID_VALID = 1'b1;
        bus.STALL    = 1'b1;
        bus.BR_TAKEN = 1'b1;
        RST          = 1'b1;
        #1;
        check("rst_op_prev",  bus.OPCODE_PREV,     0);
        check("rst_op_pp",    bus.OPCODE_PREVPREV, 0);
        check("rst_exrd",     bus.EX_MEM_RD,       0);
        check("rst_wbrd",     bus.MEM_WB_RD,       0);
        check("rst_load",     bus.LOAD,            0);
        check("rst_scnt",     bus.STALL_CNT,       0);
        check("rst_fcnt",     bus.FLUSH_CNT,       0);
        check("rst_err",      bus.ERR_STALL2,      0);
        check("rst_pc_we",    bus.PC_WE,           0);
        check("rst_ifid_we",  bus.IFID_WE,         0);
        check("rst_ifid_fl",  bus.IFID_FLUSH,      0);
        check("rst_bubble",   bus.IDEX_BUBBLE,     1);
        @(negedge CLK);
        bus.ID_VALID = 1'b0;
        bus.STALL    = 1'b0;
        bus.BR_TAKEN = 1'b0;
        bus.CNT_CLR  = 1'b0;
        RST          = 1'b0;
        model_reset();
        #1;
        check_and_step();
    endtask

    initial begin
        ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_OPIMM; ops[3] = OP_OP; ops[4] = OP_BR;
        bus.ID_VALID = 0; bus.ID_OPCODE = '0; bus.ID_RD = '0; bus.ID_WRITES_RD = 0;
        bus.STALL = 0; bus.BR_TAKEN = 0; bus.CNT_CLR = 0;
        model_reset();
        do_reset();

        cycle(1, OP_OPIMM, 5'd1, 1, 0, 0, 0);
        check("rel_pc_we", bus.PC_WE, 1);

        // ADDI x5 then ADD x6
        cycle(1, OP_OPIMM, 5'd5, 1, 0, 0, 0);
        @(posedge CLK); #1;
        check("addi_exrd", bus.EX_MEM_RD, 5);
        cycle(1, OP_OP, 5'd6, 1, 0, 0, 0);
        @(posedge CLK); #1;
        check("addi_wbrd", bus.MEM_WB_RD, 5);
        check("add_exrd",  bus.EX_MEM_RD, 6);

        // Store does not write rd
        cycle(1, OP_STORE, 5'd9, 0, 0, 0, 0);
        @(posedge CLK); #1;
        check("st_op", bus.OPCODE_PREV, OP_STORE);
        check("st_rd", bus.EX_MEM_RD, 0);

        // Load-use: LW x3 then one stall cycle
        cycle(1, OP_LOAD, 5'd3, 1, 0, 0, 0);
        cycle(1, OP_OP, 5'd4, 1, 1, 0, 0);
        check("lu_load", bus.LOAD, 1);
        cycle(1, OP_OP, 5'd4, 1, 0, 0, 0);
        check("lu_scnt", bus.STALL_CNT, 1);

        // STALL and BR_TAKEN together, then STALL while flushing
        cycle(1, OP_LOAD, 5'd7, 1, 0, 0, 0);
        cycle(1, OP_OP, 5'd7, 1, 1, 1, 0);
        cycle(1, OP_OP, 5'd8, 1, 1, 0, 0);
        check("br_fcnt", bus.FLUSH_CNT, 1);
        cycle(1, OP_OP, 5'd8, 1, 0, 0, 0);

        // Long stall run: saturation and sticky error
        for (int i = 0; i < 20; i++) cycle(1, OP_OP, 5'd2, 1, 1, 0, 0);
        cycle(1, OP_OP, 5'd2, 1, 0, 0, 0);
        check("sat_scnt", bus.STALL_CNT, CMAX);
        check("err_set",  bus.ERR_STALL2, 1);
        cycle(0, 7'd0, 5'd0, 0, 0, 0, 1);
        cycle(0, 7'd0, 5'd0, 0, 0, 0, 0);
        check("clr_scnt", bus.STALL_CNT, 0);
        check("err_sticky", bus.ERR_STALL2, 1);

        // Branch run saturates the flush counter
        for (int i = 0; i < 18; i++) cycle(1, OP_OP, 5'd1, 1, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) != 0, ops[$urandom_range(0, 4)],
                      5'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0);
            end
        end

        do_reset();
        check("err_cleared", bus.ERR_STALL2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
